// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : conv2d_pkg
//  Description : Shared types, geometry helpers and the output post-processing
//                function (shift, bias, saturate, optional ReLU) for the
//                streaming convolution layer.
//  Contents    : state_t (LOAD/COMPUTE), out_dim(), acc_width(), sat_relu()
//                and the derived geometry of the default configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv2d_pkg;

  // Default configuration; the engine itself is generic.
  localparam int DEF_DATA_W = 17;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 2;

  // Working width of the post-processing arithmetic. Wide enough for any
  // accumulator plus bias without wrap for sensible DATA_W/K choices.
  localparam int SAT_W = 64;

  typedef enum logic [0:0] {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  // ceil(img / stride)
  function automatic int out_dim(input int img, input int stride);
    return (img + stride - 1) / stride;
  endfunction

  // Full-precision sum of K*K products of two DATA_W signed values.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  localparam int P     = DEF_K / 2;
  localparam int OUT_H = out_dim(DEF_IMG_H, DEF_STRIDE);
  localparam int OUT_W = out_dim(DEF_IMG_W, DEF_STRIDE);
  localparam int ACC_W = acc_width(DEF_DATA_W, DEF_K);

  // Arithmetic shift drops the fraction (rounds toward -inf), then bias,
  // then clamp to the signed DATA_W range, then optional ReLU.
  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] bias,
    input logic                    relu_en,
    input int                      nfrac,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    maxv = (SAT_W'(64'sd1) <<< (data_w - 1)) - SAT_W'(64'sd1);
    minv = -(SAT_W'(64'sd1) <<< (data_w - 1));
    s    = (acc >>> nfrac) + bias;
    if (s > maxv) begin
      s = maxv;
    end else if (s < minv) begin
      s = minv;
    end
    if (relu_en && (s < 0)) begin
      s = '0;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_window_mac
//  Description : Combinational KxK window gather from the frame buffer with
//                zero padding outside the image, multiplied and accumulated
//                against one filter's taps at full precision.
//  Ports       : pix_i  - flattened frame buffer, pixel (r,c) at r*IMG_W+c
//                crow_i - window centre row
//                ccol_i - window centre column
//                wt_i   - filter taps, tap (i,j) at index i*K+j
//                acc_o  - signed full-precision accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_window_mac #(
  parameter int DATA_W = 17,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 38
) (
  input  logic [IMG_W*IMG_H*DATA_W-1:0] pix_i,
  input  logic [31:0]                   crow_i,
  input  logic [31:0]                   ccol_i,
  input  logic [K*K*DATA_W-1:0]         wt_i,
  output logic signed [ACC_W-1:0]       acc_o
);

  localparam int PAD = K / 2;

  always_comb begin
    int                         r;
    int                         c;
    logic signed [DATA_W-1:0]   pix;
    logic signed [DATA_W-1:0]   wt;
    logic signed [2*DATA_W-1:0] prod;
    r     = 0;
    c     = 0;
    pix   = '0;
    wt    = '0;
    prod  = '0;
    acc_o = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        r = int'(crow_i) + i - PAD;
        c = int'(ccol_i) + j - PAD;
        // Taps falling into the padding border contribute nothing.
        if ((r >= 0) && (r < IMG_H) && (c >= 0) && (c < IMG_W)) begin
          pix   = pix_i[(r * IMG_W + c) * DATA_W +: DATA_W];
          wt    = wt_i[(i * K + j) * DATA_W +: DATA_W];
          prod  = pix * wt;
          acc_o = acc_o + ACC_W'(prod);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream_relu.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_stream_relu
//  Description : Streaming "same"-padded KxK convolution over one buffered
//                IMG_H x IMG_W frame, NUM_FILT filters in parallel, strided
//                output with bias, saturation and optional ReLU.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_valid/in_ready   - pixel stream handshake
//                in_pixel            - signed pixel, raster order
//                weights/biases      - filter taps and biases (latched/frame)
//                relu_en             - 1 = clamp negatives to zero
//                out_valid/out_ready - result stream handshake
//                out_data            - one DATA_W result per filter
//                out_row/out_col     - output position
//                out_last            - final output position of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream_relu
  import conv2d_pkg::*;
#(
  parameter  int DATA_W   = 17,
  parameter  int NFRAC    = 10,
  parameter  int IMG_W    = 8,
  parameter  int IMG_H    = 8,
  parameter  int K        = 3,
  parameter  int NUM_FILT = 4,
  parameter  int STRIDE   = 2,
  localparam int OUTH     = out_dim(IMG_H, STRIDE),
  localparam int OUTW     = out_dim(IMG_W, STRIDE),
  localparam int ROW_W    = (OUTH > 1) ? $clog2(OUTH) : 1,
  localparam int COL_W    = (OUTW > 1) ? $clog2(OUTW) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_pixel,
  input  logic [NUM_FILT*K*K*DATA_W-1:0] weights,
  input  logic [NUM_FILT*DATA_W-1:0]   biases,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FILT*DATA_W-1:0]   out_data,
  output logic [ROW_W-1:0]             out_row,
  output logic [COL_W-1:0]             out_col,
  output logic                         out_last
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int ACCW  = acc_width(DATA_W, K);

  state_t                         state_q;
  logic [IDX_W-1:0]               wr_idx_q;
  logic [ROW_W-1:0]               orow_q;
  logic [COL_W-1:0]               ocol_q;
  logic                           issued_q;   // every position already issued
  logic [NUM_FILT*K*K*DATA_W-1:0] wts_q;
  logic [NUM_FILT*DATA_W-1:0]     bias_q;
  logic                           relu_q;
  logic [NPIX*DATA_W-1:0]         pix_q;

  logic                           out_valid_q;
  logic [NUM_FILT*DATA_W-1:0]     out_data_q;
  logic [ROW_W-1:0]               out_row_q;
  logic [COL_W-1:0]               out_col_q;
  logic                           out_last_q;

  logic                           w_accept;
  logic                           w_frame_full;
  logic                           w_load;
  logic                           w_pos_last;
  logic [31:0]                    w_crow;
  logic [31:0]                    w_ccol;
  logic [NUM_FILT*DATA_W-1:0]     w_result;

  assign w_accept     = (state_q == LOAD) && in_valid;
  assign w_frame_full = w_accept && (wr_idx_q == IDX_W'(NPIX - 1));
  assign w_load       = !out_valid_q || out_ready;
  assign w_pos_last   = (orow_q == ROW_W'(OUTH - 1)) && (ocol_q == COL_W'(OUTW - 1));
  assign w_crow       = 32'(orow_q) * 32'(STRIDE);
  assign w_ccol       = 32'(ocol_q) * 32'(STRIDE);

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    logic signed [ACCW-1:0] acc;

    conv2d_window_mac #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .K      (K),
      .ACC_W  (ACCW)
    ) u_mac (
      .pix_i  (pix_q),
      .crow_i (w_crow),
      .ccol_i (w_ccol),
      .wt_i   (wts_q[f*K*K*DATA_W +: K*K*DATA_W]),
      .acc_o  (acc)
    );

    assign w_result[f*DATA_W +: DATA_W] = DATA_W'(sat_relu(
      SAT_W'(acc), SAT_W'($signed(bias_q[f*DATA_W +: DATA_W])),
      relu_q, NFRAC, DATA_W));
  end

  // Frame buffer: contents are meaningless until a frame is fully loaded.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      pix_q[wr_idx_q*DATA_W +: DATA_W] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      issued_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (w_frame_full) begin
            // Coefficients are frozen for the whole frame from here on.
            state_q  <= COMPUTE;
            wts_q    <= weights;
            bias_q   <= biases;
            relu_q   <= relu_en;
            wr_idx_q <= '0;
            orow_q   <= '0;
            ocol_q   <= '0;
            issued_q <= 1'b0;
          end else if (w_accept) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
          end
        end
        COMPUTE: begin
          if (w_load) begin
            if (!issued_q) begin
              out_valid_q <= 1'b1;
              out_data_q  <= w_result;
              out_row_q   <= orow_q;
              out_col_q   <= ocol_q;
              out_last_q  <= w_pos_last;
              if (w_pos_last) begin
                issued_q <= 1'b1;
              end
              if (ocol_q == COL_W'(OUTW - 1)) begin
                ocol_q <= '0;
                orow_q <= orow_q + ROW_W'(1);
              end else begin
                ocol_q <= ocol_q + COL_W'(1);
              end
            end else begin
              out_valid_q <= 1'b0;
            end
          end
          if (out_valid_q && out_ready && out_last_q) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_relu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2d_stream_relu
//  Description : Self-checking bench for conv2d_stream_relu. Two instances
//                (stride 2 and stride 1) share the stimulus; a reference
//                model pushes expected beats into per-instance queues that a
//                monitor pops on each output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream_relu;

  localparam int DW    = 17;
  localparam int NF    = 10;
  localparam int IW    = 8;
  localparam int IH    = 8;
  localparam int KK    = 3;
  localparam int NFILT = 4;
  localparam int NPIX  = IW * IH;

  typedef struct {
    int                    row;
    int                    col;
    logic [NFILT*DW-1:0]   data;
    logic                  last;
  } exp_t;

  logic                      clk;
  logic                      reset;
  logic                      in_valid;
  logic [DW-1:0]             in_pixel;
  logic [NFILT*KK*KK*DW-1:0] weights;
  logic [NFILT*DW-1:0]       biases;
  logic                      relu_en;
  logic                      out_ready;
  int                        sel;

  logic                      iv0, iv1, ir0, ir1, ov0, ov1, ol0, ol1;
  logic [NFILT*DW-1:0]       od0, od1;
  logic [1:0]                or0, oc0;
  logic [2:0]                or1, oc1;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);

  conv2d_stream_relu #(.DATA_W(DW), .NFRAC(NF), .IMG_W(IW), .IMG_H(IH), .K(KK),
                       .NUM_FILT(NFILT), .STRIDE(2)) dut (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_pixel(in_pixel),
    .weights(weights), .biases(biases), .relu_en(relu_en), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_row(or0), .out_col(oc0), .out_last(ol0));

  conv2d_stream_relu #(.DATA_W(DW), .NFRAC(NF), .IMG_W(IW), .IMG_H(IH), .K(KK),
                       .NUM_FILT(NFILT), .STRIDE(1)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_pixel(in_pixel),
    .weights(weights), .biases(biases), .relu_en(relu_en), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_row(or1), .out_col(oc1), .out_last(ol1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   img[IH][IW];
  int   wt[NFILT][KK][KK];
  int   bs[NFILT];
  bit   relu_v;
  int   rdy_mode;
  int   stall_cnt;
  bit   stall_q[2];
  logic [127:0] hold_q[2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: direct padded convolution, then shift/bias/saturate/ReLU.
  function automatic longint model(input int s, input int orow, input int ocol, input int f);
    longint acc, v, maxv;
    int r, c;
    acc = 0;
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++) begin
        r = orow * s + i - KK / 2;
        c = ocol * s + j - KK / 2;
        if (r >= 0 && r < IH && c >= 0 && c < IW)
          acc += longint'(img[r][c]) * longint'(wt[f][i][j]);
      end
    maxv = (longint'(1) << (DW - 1)) - 1;
    v = (acc >>> NF) + longint'(bs[f]);
    if (v > maxv) v = maxv;
    if (v < -maxv - 1) v = -maxv - 1;
    if (relu_v && v < 0) v = 0;
    return v;
  endfunction

  task automatic push_frame(input int k);
    int s, oh, ow;
    exp_t e;
    s  = (k == 0) ? 2 : 1;
    oh = (IH + s - 1) / s;
    ow = (IW + s - 1) / s;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        e.row  = r;
        e.col  = c;
        e.last = (r == oh - 1) && (c == ow - 1);
        e.data = '0;
        for (int f = 0; f < NFILT; f++) e.data[f*DW +: DW] = DW'(model(s, r, c, f));
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
  endtask

  task automatic apply_ports();
    for (int f = 0; f < NFILT; f++) begin
      biases[f*DW +: DW] = DW'(bs[f]);
      for (int i = 0; i < KK; i++)
        for (int j = 0; j < KK; j++)
          weights[((f*KK + i)*KK + j)*DW +: DW] = DW'(wt[f][i][j]);
    end
    relu_en = relu_v;
  endtask

  task automatic fill(input int pv, input int wv, input int bstep);
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = pv;
    for (int f = 0; f < NFILT; f++) begin
      bs[f] = f * bstep;
      for (int i = 0; i < KK; i++) for (int j = 0; j < KK; j++) wt[f][i][j] = wv;
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) img[r][c] = int'($urandom_range(0, 8192)) - 4096;
    for (int f = 0; f < NFILT; f++) begin
      bs[f] = int'($urandom_range(0, 16384)) - 8192;
      for (int i = 0; i < KK; i++)
        for (int j = 0; j < KK; j++) wt[f][i][j] = int'($urandom_range(0, 4096)) - 2048;
    end
    relu_v = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_pixel(input int v);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    in_pixel = DW'(v);
    n = 0;
    forever begin
      @(negedge clk);
      rdy = (sel == 0) ? ir0 : ir1;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 2000) begin
        check("pixel_accept_timeout", rdy, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit push, input bit gaps, input int npix);
    apply_ports();
    if (push) push_frame(sel);
    for (int p = 0; p < npix; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_pixel = DW'($urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      drive_pixel(img[p / IW][p % IW]);
    end
    if (push) begin
      // Junk offered while computing must be ignored.
      in_valid = 1'b1;
      in_pixel = DW'($urandom);
      repeat (8) begin @(posedge clk); #1; end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", q0.size() + q1.size(), 0);
    @(negedge clk);
    check("in_ready_after_last", (sel == 0) ? ir0 : ir1, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int k, input logic v, input logic ir, input logic [NFILT*DW-1:0] d,
                     input int r, input int c, input logic l);
    logic [127:0] snap;
    exp_t e;
    snap = {16'(r), 16'(c), l, d};
    if (stall_q[k]) begin
      check("hold_valid", v, 1);
      check("hold_beat", snap, hold_q[k]);
    end
    if (v) begin
      check("in_ready_in_compute", ir, 0);
      if (out_ready) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check("spurious_beat", v, 0);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check("row", r, e.row);
          check("col", c, e.col);
          check("last", l, e.last);
          check("data", d, e.data);
        end
      end
    end
    stall_q[k] = v && !out_ready;
    hold_q[k]  = snap;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall_q[0] = 1'b0;
      stall_q[1] = 1'b0;
    end else begin
      mon(0, ov0, ir0, od0, int'(or0), int'(oc0), ol0);
      mon(1, ov1, ir1, od1, int'(or1), int'(oc1), ol1);
    end
  end

  initial begin
    stall_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        out_ready = 1'b0;
        stall_cnt = 4;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    weights   = '0;
    biases    = '0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    sel       = 0;
    relu_v    = 1'b1;
    fill(1024, 1024, 0);
    apply_ports();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_valid", ov0, 0);       check("rst_valid_s1", ov1, 0);
    check("rst_data", od0, 0);        check("rst_data_s1", od1, 0);
    check("rst_row", or0, 0);         check("rst_row_s1", or1, 0);
    check("rst_col", oc0, 0);         check("rst_col_s1", oc1, 0);
    check("rst_last", ol0, 0);        check("rst_last_s1", ol1, 0);
    check("rst_in_ready", ir0, 1);    check("rst_in_ready_s1", ir1, 1);
    @(posedge clk); #1;

    // All-ones image, unit weights: stride 1 then stride 2.
    sel = 1; send_frame(1, 0, NPIX); drain();
    sel = 0; send_frame(1, 0, NPIX); drain();

    // Saturation and ReLU.
    fill(10240, 1024, 0);  relu_v = 1'b1; send_frame(1, 0, NPIX); drain();
    fill(10240, -1024, 0); relu_v = 1'b1; send_frame(1, 0, NPIX); drain();
    relu_v = 1'b0; send_frame(1, 0, NPIX); drain();

    // Zero weights expose the bias path only.
    fill(3000, 0, 1024); relu_v = 1'b1; send_frame(1, 0, NPIX); drain();

    // Random data, backpressure, input gaps, back-to-back frames.
    rdy_mode = 1;
    sel = 0;
    fill_random(); send_frame(1, 1, NPIX);
    fill_random(); send_frame(1, 1, NPIX);
    drain();
    sel = 1; fill_random(); send_frame(1, 1, NPIX); drain();
    rdy_mode = 0;

    // Reset in the middle of loading discards the partial frame.
    sel = 0;
    fill_random(); send_frame(0, 1, 30);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", ir0, 1);
    check("post_rst_valid", ov0, 0);
    @(posedge clk); #1;
    fill_random(); send_frame(1, 0, NPIX); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv2d_stream_relu.md
Name: conv2d_stream_relu

Overview:
Parametrised streaming 2D convolution layer with a frame buffer. It accepts one image of IMG_H x IMG_W signed fixed-point pixels over a valid/ready input stream, then computes a "same"-padded KxK convolution for NUM_FILT filters in parallel. Outputs are produced at a configurable stride, with bias, saturation and optional ReLU, on a valid/ready output stream. It is the first-layer conv engine: the next generation of the fixed 8x8 / 3x3 / stride-2 layer, adding backpressure, runtime ReLU bypass, saturation and generic dimensions.

Parameters:
DATA_W, 17, signed pixel/weight/bias/output width
NFRAC, 10, fractional bits (Q(DATA_W-NFRAC).NFRAC)
IMG_W, 8, image width in pixels
IMG_H, 8, image height in pixels
K, 3, filter dimension (odd, >=1); padding P = K/2
NUM_FILT, 4, number of filters / output channels
STRIDE, 2, output stride (1..K)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts pixel
in_pixel  in  DATA_W  signed pixel, raster order (row-major, col fastest)
weights  in  NUM_FILT*K*K*DATA_W  signed; filter f, tap (i,j) at index (f*K+i)*K+j
biases  in  NUM_FILT*DATA_W  signed, bias f at index f
relu_en  in  1  1 = apply ReLU, 0 = bypass
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
out_data  out  NUM_FILT*DATA_W  signed result per filter, filter f at index f
out_row  out  clog2(OUT_H)  output row index
out_col  out  clog2(OUT_W)  output column index
out_last  out  1  high with final output of frame

Behaviour:
- OUT_H = ceil(IMG_H/STRIDE), OUT_W = ceil(IMG_W/STRIDE). Output (orow,ocol) is centred on pixel (orow*STRIDE, ocol*STRIDE). Taps outside the image read 0.
- FSM: LOAD -> COMPUTE -> LOAD. Reset state is LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready writes the pixel to buffer[wr_idx] and increments wr_idx. Accepting pixel IMG_W*IMG_H-1 moves to COMPUTE next cycle. On that same transition, weights, biases and relu_en are latched into internal registers; later changes on those ports do not affect the frame.
- COMPUTE: in_ready=0. A position counter walks (orow,ocol) in raster order.
- Output register update rule: the register loads a new result when !out_valid || out_ready. Otherwise out_data, out_row, out_col and out_last hold stable.
- First out_valid appears 1 cycle after entering COMPUTE. Throughput is 1 output/cycle while out_ready=1.
- After the handshake of the out_last beat, return to LOAD with wr_idx=0. in_ready rises the cycle after that handshake.
- Arithmetic per filter:
  - acc = sum of pixel*weight over K*K taps; full precision, width 2*DATA_W+clog2(K*K).
  - Arithmetic shift right by NFRAC (truncate toward -inf).
  - Add sign-extended bias.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If relu_en, clamp negatives to 0.
- out_last=1 only on (OUT_H-1, OUT_W-1).
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, in_ready=1 (first cycle after reset deassert), wr_idx=0. Buffer contents are don't-care.
- Reset mid-LOAD or mid-COMPUTE: the partial frame is discarded, any pending output is dropped and the FSM returns to LOAD.
- in_valid during COMPUTE is ignored (in_ready=0). No pixel loss occurs as long as the source honours ready.

Decomposition:
- Package conv2d_pkg: localparams P, OUT_H, OUT_W, ACC_W; FSM state enum {LOAD, COMPUTE}; function sat_relu(acc, bias, relu_en).
- Sub-module conv2d_window_mac: combinational KxK gather (with padding zeros) and MAC for one filter. Instantiated NUM_FILT times via generate.

Test Plan:
- Stride 1, all pixels 1.0 (1024), all weights 1.0, biases 0, relu_en=1 -> 64 outputs. Corners 4096, non-corner edges 6144, interior 9216 on every filter. out_last only on (7,7).
- Default stride 2, same image -> 16 outputs. (0,0)=4096, (0,1)=6144, (1,1)=9216. out_row/out_col raster sequence correct.
- Pixels 10.0 (10240), weights 1.0 -> interior 92160 saturates to 65535. With weights -1.0: relu_en=1 gives 0, relu_en=0 gives -65536.
- Filter f biases f*1024, weights 0 -> out_data filter f = f*1024 everywhere.
- Random out_ready with 5-cycle low stalls and random in_valid gaps -> output stable during stalls, no drop or duplicate, 16 beats per frame, in_ready=0 throughout COMPUTE. Two back-to-back frames are both correct.
- Assert reset after 30 pixels, then send a full frame -> no outputs from the partial frame; the new frame's results match the reference model.
